// File: rtl/result_checker_if.sv
// Memory read port and expected-value table port of the post-run result checker.
// The checker drives address/index (master); the memory and table side answers (slave).
interface result_checker_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 7
);
    logic              rd_en;
    logic [31:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_mask;

    modport master (
        output rd_en, rd_addr, exp_idx,
        input  rd_data, exp_data, exp_mask
    );

    modport slave (
        input  rd_en, rd_addr, exp_idx,
        output rd_data, exp_data, exp_mask
    );
endinterface

// File: rtl/result_checker.sv
// Post-run result checker: walks WORDS memory words after the core halts, compares each
// against a masked expected table, counts mismatches and streams per-word error records.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no check since reset; waiting for a trigger
// S_ISSUE | read request for the current word (rd_en high)
// S_WAIT  | address held while the read port latency elapses
// S_CMP   | read data and expected entry sampled and compared
// S_DONE  | walk finished; done/pass and results held until retrigger
module result_checker #(
    parameter int          WORDS      = 66,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter logic [31:0] STRIDE     = 32'd4,
    parameter int          RD_LAT     = 0,
    parameter int          CNT_W      = 16,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              halted,
    result_checker_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_valid,
    output logic [31:0]       err_addr,
    output logic [DATA_W-1:0] err_got,
    output logic [DATA_W-1:0] err_exp,
    output logic [31:0]       first_err_addr,
    output logic              first_err_valid
);
    localparam int               IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [1:0]       WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       wait_cnt;
    logic             halted_q;
    logic             rd_en_q;
    logic [31:0]      addr_q;

    logic trigger;
    logic mismatch;
    logic last_word;

    // start and a halted edge in the same cycle collapse into one trigger
    assign trigger   = ((state == S_IDLE) || (state == S_DONE)) &&
                       (start || (AUTO_START && halted && !halted_q));
    assign mismatch  = |((bus.rd_data ^ bus.exp_data) & bus.exp_mask);
    assign last_word = (idx == LAST_IDX);

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = addr_q;
    assign bus.exp_idx = idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            idx             <= '0;
            wait_cnt        <= 2'd0;
            halted_q        <= 1'b0;
            rd_en_q         <= 1'b0;
            addr_q          <= 32'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            err_valid       <= 1'b0;
            err_addr        <= 32'd0;
            err_got         <= '0;
            err_exp         <= '0;
            first_err_addr  <= 32'd0;
            first_err_valid <= 1'b0;
        end else begin
            halted_q  <= halted;
            err_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (trigger) begin
                        state           <= S_ISSUE;
                        idx             <= '0;
                        addr_q          <= ADDR_BASE;
                        rd_en_q         <= 1'b1;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_addr  <= 32'd0;
                        first_err_valid <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    rd_en_q <= 1'b0;
                    if (RD_LAT > 0) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= S_CMP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_CMP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_CMP: begin
                    if (mismatch) begin
                        err_valid <= 1'b1;
                        err_addr  <= addr_q;
                        err_got   <= bus.rd_data;
                        err_exp   <= bus.exp_data;
                        if (err_count != CNT_MAX) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_addr  <= addr_q;
                        end
                    end
                    // pass must account for the word being compared right now
                    if (last_word) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state   <= S_ISSUE;
                        idx     <= idx + IDX_W'(1);
                        addr_q  <= addr_q + STRIDE;
                        rd_en_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
